// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl: built-in self-test sequencer for the two-input gate block.
// It takes over the gate inputs, walks all four {a,b} vectors and holds each
// one for SETTLE cycles. It then samples the seven gate outputs against the
// ideal truth table and keeps a small pass/fail record for the status logic.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic [6:0] gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [1:0] fail_vec,
    output logic [6:0] fail_mask
);

    // Last APPLY cycle index for a vector; the settle counter is 4 bits wide.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] fail_count_q, fail_count_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [6:0] fail_mask_q, fail_mask_d;
    logic       pass_q, pass_d;

    logic [6:0] exp_out;
    logic       mismatch;

    // Ideal gate outputs for the vector currently applied.
    // Bit order is and, or, not(A), nand, nor, xor, xnor.
    always_comb begin
        exp_out = 7'h00;
        unique case (vec_q)
            2'b00:   exp_out = 7'h5C;
            2'b01:   exp_out = 7'h2E;
            2'b10:   exp_out = 7'h2A;
            default: exp_out = 7'h43;
        endcase
    end

    assign mismatch = (gate_out != exp_out);

    // Register the sequencer state and the result record; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= 2'd0;
            cnt_q        <= 4'd0;
            fail_count_q <= 3'd0;
            fail_vec_q   <= 2'd0;
            fail_mask_q  <= 7'd0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_count_q <= fail_count_d;
            fail_vec_q   <= fail_vec_d;
            fail_mask_q  <= fail_mask_d;
            pass_q       <= pass_d;
        end
    end

    // Compute the next state and result updates. The results only change on an
    // accepted start (clear), on a failing sample, or when entering DONE (pass).
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_count_d = fail_count_q;
        fail_vec_d   = fail_vec_q;
        fail_mask_d  = fail_mask_q;
        pass_d       = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = APPLY;
                    vec_d        = 2'd0;
                    cnt_d        = 4'd0;
                    fail_count_d = 3'd0;
                    fail_vec_d   = 2'd0;
                    fail_mask_d  = 7'd0;
                    pass_d       = 1'b0;
                end
            end

            APPLY: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + 3'd1;
                    if (fail_count_q == 3'd0) begin
                        fail_vec_d  = vec_q;
                        fail_mask_d = gate_out ^ exp_out;
                    end
                end
                if ((vec_q == 2'd3) || (mismatch && STOP_ON_FAIL)) begin
                    state_d = DONE;
                    pass_d  = (fail_count_d == 3'd0);
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = 4'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The gate inputs are only driven while a vector is being applied or
    // sampled. Outside a run they rest at 0.
    always_comb begin
        gate_a = 1'b0;
        gate_b = 1'b0;
        if ((state_q == APPLY) || (state_q == SAMPLE)) begin
            gate_a = vec_q[1];
            gate_b = vec_q[0];
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign fail_vec   = fail_vec_q;
    assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl: directed bench for gate_bist_ctrl. Three instances cover
// SETTLE=1, SETTLE=1 with STOP_ON_FAIL, and SETTLE=3. Each instance is driven
// by a behavioural gate model that can inject a stuck xor or an inverted not.
module tb_gate_bist_ctrl;

    logic       clk;
    logic [2:0] rst;
    logic [2:0] start;
    logic [2:0] gateA;
    logic [2:0] gateB;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] pass;
    logic [6:0] gateOut   [3];
    logic [2:0] failCount [3];
    logic [1:0] failVec   [3];
    logic [6:0] failMask  [3];
    int         faultMode [3];

    int compareCount;
    int mismatchCount;

    int         doneCycle;
    int         busyCycles;
    int         doneCount;
    logic [1:0] vecLog [0:63];
    logic [2:0] snapCount;
    logic [6:0] snapMask;
    logic       snapPass;
    logic       busyAfterDone;
    logic       doneAfterDone;

    // Gate block model built from real operators; mode 1 sticks xor at 0,
    // mode 2 inverts the not output.
    function automatic logic [6:0] gateModel(input logic a, input logic b, input int mode);
        logic [6:0] o;
        o = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        if (mode == 1) o[5] = 1'b0;
        if (mode == 2) o[2] = ~o[2];
        return o;
    endfunction

    // Instances: 0 = SETTLE 1, 1 = SETTLE 1 stop-on-fail, 2 = SETTLE 3.
    for (genvar g = 0; g < 3; g++) begin : gInst
        assign gateOut[g] = gateModel(gateA[g], gateB[g], faultMode[g]);

        gate_bist_ctrl #(
            .SETTLE       ((g == 2) ? 3 : 1),
            .STOP_ON_FAIL (g == 1)
        ) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .start      (start[g]),
            .gate_a     (gateA[g]),
            .gate_b     (gateB[g]),
            .gate_out   (gateOut[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .pass       (pass[g]),
            .fail_count (failCount[g]),
            .fail_vec   (failVec[g]),
            .fail_mask  (failMask[g])
        );
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something leaves the bench waiting forever.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Pulse start for one instance and log the gate vector each cycle until done
    // (cycle 1 is the cycle after the accepting edge). Then hold start through
    // DONE to confirm it is not accepted there.
    task automatic applyStimulus(input int idx, input bit pulseMid);
        doneCycle  = 0;
        busyCycles = 0;
        @(negedge clk);
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            vecLog[cyc] = {gateA[idx], gateB[idx]};
            if (cyc == 1) begin
                snapCount = failCount[idx];
                snapMask  = failMask[idx];
                snapPass  = pass[idx];
            end
            if (busy[idx]) busyCycles++;
            if (pulseMid && cyc == 6) start[idx] = 1'b1;
            if (pulseMid && cyc == 8) start[idx] = 1'b0;
            if (done[idx]) begin
                doneCycle = cyc;
                break;
            end
        end
        start[idx] = 1'b1;
        @(posedge clk);
        #1;
        start[idx] = 1'b0;
        busyAfterDone = busy[idx];
        doneAfterDone = done[idx];
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst   = 3'b111;
        start = 3'b000;
        for (int i = 0; i < 3; i++) faultMode[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 3'b000;

        // Reset state
        checkOutput("rst_busy0",  busy[0],      1'b0);
        checkOutput("rst_done0",  done[0],      1'b0);
        checkOutput("rst_pass0",  pass[0],      1'b0);
        checkOutput("rst_ab0",    {gateA[0], gateB[0]}, 2'b00);
        checkOutput("rst_cnt0",   failCount[0], 3'd0);
        checkOutput("rst_vec0",   failVec[0],   2'd0);
        checkOutput("rst_mask0",  failMask[0],  7'h00);
        checkOutput("rst_busy12", busy[2:1],    2'b00);

        // Golden run, SETTLE=1
        applyStimulus(0, 1'b0);
        checkOutput("gold_doneCyc", doneCycle,  9);
        checkOutput("gold_busyCyc", busyCycles, 9);
        checkOutput("gold_v1",  vecLog[1], 2'b00);
        checkOutput("gold_v2",  vecLog[2], 2'b00);
        checkOutput("gold_v3",  vecLog[3], 2'b01);
        checkOutput("gold_v4",  vecLog[4], 2'b01);
        checkOutput("gold_v5",  vecLog[5], 2'b10);
        checkOutput("gold_v7",  vecLog[7], 2'b11);
        checkOutput("gold_v8",  vecLog[8], 2'b11);
        checkOutput("gold_v9",  vecLog[9], 2'b00);
        checkOutput("gold_pass", pass[0],      1'b1);
        checkOutput("gold_cnt",  failCount[0], 3'd0);
        checkOutput("gold_mask", failMask[0],  7'h00);
        checkOutput("gold_noStartInDone", busyAfterDone, 1'b0);
        checkOutput("gold_donePulse",     doneAfterDone, 1'b0);

        // xor stuck-at-0, full run
        faultMode[0] = 1;
        applyStimulus(0, 1'b0);
        checkOutput("xor_doneCyc", doneCycle,    9);
        checkOutput("xor_cnt",     failCount[0], 3'd2);
        checkOutput("xor_vec",     failVec[0],   2'b01);
        checkOutput("xor_mask",    failMask[0],  7'h20);
        checkOutput("xor_pass",    pass[0],      1'b0);

        // xor stuck-at-0 with stop-on-fail
        faultMode[1] = 1;
        applyStimulus(1, 1'b0);
        checkOutput("stop_doneCyc", doneCycle,    5);
        checkOutput("stop_busyCyc", busyCycles,   5);
        checkOutput("stop_cnt",     failCount[1], 3'd1);
        checkOutput("stop_vec",     failVec[1],   2'b01);
        checkOutput("stop_mask",    failMask[1],  7'h20);
        checkOutput("stop_pass",    pass[1],      1'b0);

        // SETTLE=3 golden run with a stray start mid-run
        applyStimulus(2, 1'b1);
        checkOutput("s3_doneCyc", doneCycle,  17);
        checkOutput("s3_busyCyc", busyCycles, 17);
        checkOutput("s3_v1",  vecLog[1],  2'b00);
        checkOutput("s3_v4",  vecLog[4],  2'b00);
        checkOutput("s3_v5",  vecLog[5],  2'b01);
        checkOutput("s3_v8",  vecLog[8],  2'b01);
        checkOutput("s3_v9",  vecLog[9],  2'b10);
        checkOutput("s3_v13", vecLog[13], 2'b11);
        checkOutput("s3_v16", vecLog[16], 2'b11);
        checkOutput("s3_pass", pass[2],   1'b1);

        // Reset during APPLY of vector 10 (cycle 5), with one failure already logged
        faultMode[0] = 1;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("abort_preVec", {gateA[0], gateB[0]}, 2'b10);
        checkOutput("abort_preCnt", failCount[0], 3'd1);
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        checkOutput("abort_busy", busy[0],      1'b0);
        checkOutput("abort_done", done[0],      1'b0);
        checkOutput("abort_ab",   {gateA[0], gateB[0]}, 2'b00);
        checkOutput("abort_res",  {pass[0], failCount[0], failVec[0], failMask[0]}, 13'd0);
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done[0]) doneCount++;
        end
        checkOutput("abort_noDone", doneCount, 0);
        faultMode[0] = 0;
        applyStimulus(0, 1'b0);
        checkOutput("rerun_doneCyc", doneCycle, 9);
        checkOutput("rerun_v1",  vecLog[1], 2'b00);
        checkOutput("rerun_v3",  vecLog[3], 2'b01);
        checkOutput("rerun_pass", pass[0],  1'b1);

        // Inverted not output fails every vector
        faultMode[0] = 2;
        applyStimulus(0, 1'b0);
        checkOutput("not_cnt",  failCount[0], 3'd4);
        checkOutput("not_vec",  failVec[0],   2'b00);
        checkOutput("not_mask", failMask[0],  7'h04);
        checkOutput("not_pass", pass[0],      1'b0);

        // Golden run afterwards: results cleared on acceptance
        faultMode[0] = 0;
        applyStimulus(0, 1'b0);
        checkOutput("clr_snapCnt",  snapCount, 3'd0);
        checkOutput("clr_snapMask", snapMask,  7'h00);
        checkOutput("clr_snapPass", snapPass,  1'b0);
        checkOutput("clr_pass",     pass[0],      1'b1);
        checkOutput("clr_cnt",      failCount[0], 3'd0);
        checkOutput("clr_mask",     failMask[0],  7'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
